// File: rtl/simd_issue_buffer.sv
// Serial-to-parallel operand stager and parallel-to-serial result drainer for the SIMD core.
// Optional synchronous flush port is enabled by defining SIMD_ISSUE_FLUSH_EN.
module simd_issue_buffer #(
  parameter  int ALUWIDTH = 16,
  localparam int IDXW     = (ALUWIDTH > 1) ? $clog2(ALUWIDTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
`ifdef SIMD_ISSUE_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_opA,
  input  logic [31:0]              in_opB,
  input  logic [2:0]               in_cmd,
  output logic [32*ALUWIDTH-1:0]   core_OperandA_s,
  output logic [32*ALUWIDTH-1:0]   core_OperandB_s,
  output logic [2:0]               core_command,
  input  logic [32*ALUWIDTH-1:0]   core_result_s,
  input  logic [ALUWIDTH-1:0]      core_iszero_s,
  input  logic [ALUWIDTH-1:0]      core_overflow_s,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_result,
  output logic                     out_iszero,
  output logic                     out_overflow,
  output logic [IDXW-1:0]          out_lane,
  output logic                     out_last
);

  typedef enum logic [1:0] {S_FILL, S_EXEC, S_DRAIN} state_t;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(ALUWIDTH - 1);

  state_t          state_reg, state_next;
  logic [IDXW-1:0] fill_idx_reg, fill_idx_next;
  logic [IDXW-1:0] drain_idx_reg, drain_idx_next;
  logic [2:0]      cmd_reg;
  logic [31:0]     op_a_reg [ALUWIDTH];
  logic [31:0]     op_b_reg [ALUWIDTH];
  logic [31:0]     res_reg  [ALUWIDTH];
  logic [31:0]     res_in   [ALUWIDTH];
  logic [ALUWIDTH-1:0] iszero_reg, overflow_reg;
  logic            flush_req, accept, drain_take, capture;

`ifdef SIMD_ISSUE_FLUSH_EN
  assign flush_req = flush;
`else
  assign flush_req = 1'b0;
`endif

  assign in_ready   = (state_reg == S_FILL);
  assign out_valid  = (state_reg == S_DRAIN);
  // Flush wins over any handshake and over the EXEC capture.
  assign accept     = in_valid && in_ready && !flush_req;
  assign drain_take = out_valid && out_ready && !flush_req;
  assign capture    = (state_reg == S_EXEC) && !flush_req;

  generate
    for (genvar gi = 0; gi < ALUWIDTH; gi++) begin : g_lane
      assign core_OperandA_s[32*gi +: 32] = op_a_reg[gi];
      assign core_OperandB_s[32*gi +: 32] = op_b_reg[gi];
      assign res_in[gi]                   = core_result_s[32*gi +: 32];
    end
  endgenerate

  assign core_command = cmd_reg;
  assign out_result   = res_reg[drain_idx_reg];
  assign out_iszero   = iszero_reg[drain_idx_reg];
  assign out_overflow = overflow_reg[drain_idx_reg];
  assign out_lane     = drain_idx_reg;
  assign out_last     = out_valid && (drain_idx_reg == LAST_IDX);

  always_comb begin
    state_next     = state_reg;
    fill_idx_next  = fill_idx_reg;
    drain_idx_next = drain_idx_reg;
    case (state_reg)
      S_FILL: begin
        if (accept) begin
          if (fill_idx_reg == LAST_IDX) begin
            state_next    = S_EXEC;
            fill_idx_next = '0;
          end else begin
            fill_idx_next = fill_idx_reg + 1'b1;
          end
        end
      end
      S_EXEC: state_next = S_DRAIN;
      S_DRAIN: begin
        if (drain_take) begin
          if (drain_idx_reg == LAST_IDX) begin
            state_next     = S_FILL;
            drain_idx_next = '0;
          end else begin
            drain_idx_next = drain_idx_reg + 1'b1;
          end
        end
      end
      default: state_next = S_FILL;
    endcase
    if (flush_req) begin
      state_next     = S_FILL;
      fill_idx_next  = '0;
      drain_idx_next = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= S_FILL;
      fill_idx_reg  <= '0;
      drain_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      fill_idx_reg  <= fill_idx_next;
      drain_idx_reg <= drain_idx_next;
    end
  end

  // Operand lanes are written one per accepted beat; results all at once in EXEC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_reg      <= '0;
      iszero_reg   <= '0;
      overflow_reg <= '0;
      for (int i = 0; i < ALUWIDTH; i++) begin
        op_a_reg[i] <= '0;
        op_b_reg[i] <= '0;
        res_reg[i]  <= '0;
      end
    end else begin
      if (accept && (fill_idx_reg == '0)) begin
        cmd_reg <= in_cmd;
      end
      for (int i = 0; i < ALUWIDTH; i++) begin
        if (accept && (fill_idx_reg == IDXW'(i))) begin
          op_a_reg[i] <= in_opA;
          op_b_reg[i] <= in_opB;
        end
        if (capture) begin
          res_reg[i] <= res_in[i];
        end
      end
      if (capture) begin
        iszero_reg   <= core_iszero_s;
        overflow_reg <= core_overflow_s;
      end
    end
  end

endmodule
